// File: rtl/medicine_schedule_keeper.sv
// medicine_schedule_keeper: slot table of medicine IDs with hourly countdowns and an
// acknowledged reminder that serves due slots one at a time, lowest index first.
module medicine_schedule_keeper #(
   parameter int SLOTS = 4,
   parameter int ID_W  = 6,
   parameter int INT_W = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Sel_Valid,
   input  logic [ID_W-1:0]  Selected_Address,
   input  logic [INT_W-1:0] Selected_Data,
   input  logic             Hour_Tick,
   input  logic             Ack_Button,
   output logic             Alarm,
   output logic [ID_W-1:0]  Alarm_Med_Id,
   output logic [3:0]       Active_Count,
   output logic             Full_Err
);
   localparam int IW = $clog2(SLOTS);
   typedef enum logic {IDLE, ALARM} state_t;
   state_t state, state_nx;
   logic [SLOTS-1:0] valid, valid_nx, due, due_nx;
   logic [ID_W-1:0]  id [SLOTS];
   logic [ID_W-1:0]  id_nx [SLOTS];
   logic [INT_W-1:0] intv [SLOTS];
   logic [INT_W-1:0] intv_nx [SLOTS];
   logic [INT_W-1:0] cnt [SLOTS];
   logic [INT_W-1:0] cnt_nx [SLOTS];
   logic [IW-1:0]    k, k_nx, hit_idx, free_idx, due_idx, wr_idx;
   logic [ID_W-1:0]  med_nx;
   logic [3:0]       act_nx;
   logic             hit, free, wr, full_nx;
   assign Alarm = (state == ALARM);
   always_comb begin
      hit = 1'b0;
      free = 1'b0;
      hit_idx = '0;
      free_idx = '0;
      due_idx = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (valid[i] && id[i] == Selected_Address) begin
            hit = 1'b1;
            hit_idx = IW'(i);
         end
         if (!valid[i]) begin
            free = 1'b1;
            free_idx = IW'(i);
         end
         if (due[i]) due_idx = IW'(i);
      end
      wr = Sel_Valid && (hit || (Selected_Data != '0 && free));
      wr_idx = hit ? hit_idx : free_idx;
      full_nx = Sel_Valid && !hit && Selected_Data != '0 && !free;
      valid_nx = valid;
      due_nx = due;
      if (state == ALARM && Ack_Button) due_nx[k] = 1'b0;
      act_nx = '0;
      for (int i = 0; i < SLOTS; i++) begin
         id_nx[i] = id[i];
         intv_nx[i] = intv[i];
         cnt_nx[i] = cnt[i];
         // A write owns its slot this cycle, so a simultaneous tick skips it
         if (wr && wr_idx == IW'(i)) begin
            valid_nx[i] = Selected_Data != '0;
            id_nx[i] = Selected_Address;
            intv_nx[i] = Selected_Data;
            cnt_nx[i] = Selected_Data;
            due_nx[i] = 1'b0;
         end else if (Hour_Tick && valid[i]) begin
            due_nx[i] = (cnt[i] == INT_W'(1)) ? 1'b1 : due_nx[i];
            cnt_nx[i] = (cnt[i] == INT_W'(1)) ? intv[i] : cnt[i] - INT_W'(1);
         end
         act_nx = act_nx + 4'(valid_nx[i]);
      end
      state_nx = state;
      k_nx = k;
      med_nx = Alarm_Med_Id;
      if (state == IDLE && |due) begin
         state_nx = ALARM;
         k_nx = due_idx;
         med_nx = id[due_idx];
      end else if (state == ALARM && (Ack_Button || (wr && wr_idx == k))) begin
         state_nx = IDLE;
      end
   end
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= IDLE;
         valid <= '0;
         due <= '0;
         k <= '0;
         Alarm_Med_Id <= '0;
         Active_Count <= '0;
         Full_Err <= 1'b0;
         for (int i = 0; i < SLOTS; i++) begin
            id[i] <= '0;
            intv[i] <= '0;
            cnt[i] <= '0;
         end
      end else begin
         state <= state_nx;
         valid <= valid_nx;
         due <= due_nx;
         k <= k_nx;
         Alarm_Med_Id <= med_nx;
         Active_Count <= act_nx;
         Full_Err <= full_nx;
         for (int i = 0; i < SLOTS; i++) begin
            id[i] <= id_nx[i];
            intv[i] <= intv_nx[i];
            cnt[i] <= cnt_nx[i];
         end
      end
   end
endmodule

// File: tb/tb_medicine_schedule_keeper.sv
// tb_medicine_schedule_keeper: directed vectors with hand-computed expectations.
module tb_medicine_schedule_keeper;
   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic       Sel_Valid = 1'b0;
   logic [5:0] Selected_Address = '0;
   logic [3:0] Selected_Data = '0;
   logic       Hour_Tick = 1'b0;
   logic       Ack_Button = 1'b0;
   logic       Alarm;
   logic [5:0] Alarm_Med_Id;
   logic [3:0] Active_Count;
   logic       Full_Err;
   int checks = 0;
   int errors = 0;
   medicine_schedule_keeper dut (
      .Clk(Clk), .Rst(Rst), .Sel_Valid(Sel_Valid),
      .Selected_Address(Selected_Address), .Selected_Data(Selected_Data),
      .Hour_Tick(Hour_Tick), .Ack_Button(Ack_Button), .Alarm(Alarm),
      .Alarm_Med_Id(Alarm_Med_Id), .Active_Count(Active_Count), .Full_Err(Full_Err)
   );
   always #5 Clk = ~Clk;
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge Clk);
      #1;
   endtask
   task automatic sel(input int a, input int d);
      Sel_Valid = 1'b1;
      Selected_Address = 6'(a);
      Selected_Data = 4'(d);
      step();
      Sel_Valid = 1'b0;
   endtask
   task automatic tick();
      Hour_Tick = 1'b1;
      step();
      Hour_Tick = 1'b0;
   endtask
   task automatic ack();
      Ack_Button = 1'b1;
      step();
      Ack_Button = 1'b0;
   endtask
   task automatic reset();
      Rst = 1'b0;
      step();
      Rst = 1'b1;
      step();
   endtask
   initial begin
      reset();
      check("rst_alarm", Alarm, 0);
      check("rst_med", Alarm_Med_Id, 0);
      check("rst_count", Active_Count, 0);
      check("rst_full", Full_Err, 0);
      // single medicine, interval 2
      sel(5, 2);
      check("t1_count", Active_Count, 1);
      tick();
      tick();
      check("t1_alarm_latency", Alarm, 0);
      step();
      check("t1_alarm", Alarm, 1);
      check("t1_med", Alarm_Med_Id, 5);
      ack();
      check("t1_ack", Alarm, 0);
      check("t1_med_hold", Alarm_Med_Id, 5);
      tick();
      step();
      check("t1_one_tick", Alarm, 0);
      tick();
      step();
      check("t1_realarm", Alarm, 1);
      // table full, delete, refill lands in slot 1
      reset();
      sel(1, 3);
      sel(2, 3);
      sel(3, 3);
      sel(4, 3);
      check("t2_count4", Active_Count, 4);
      sel(9, 3);
      check("t2_full", Full_Err, 1);
      check("t2_count_full", Active_Count, 4);
      step();
      check("t2_full_pulse", Full_Err, 0);
      sel(2, 0);
      check("t2_delete", Active_Count, 3);
      sel(9, 3);
      check("t2_readd", Active_Count, 4);
      check("t2_no_full", Full_Err, 0);
      tick();
      tick();
      tick();
      step();
      check("t2_first_med", Alarm_Med_Id, 1);
      ack();
      step();
      check("t2_slot1_alarm", Alarm, 1);
      check("t2_slot1_med", Alarm_Med_Id, 9);
      // two due together: served in slot order with one idle cycle between
      reset();
      sel(7, 1);
      sel(8, 1);
      tick();
      step();
      check("t3_alarm7", Alarm, 1);
      check("t3_med7", Alarm_Med_Id, 7);
      ack();
      check("t3_idle_gap", Alarm, 0);
      step();
      check("t3_alarm8", Alarm, 1);
      check("t3_med8", Alarm_Med_Id, 8);
      // write and tick in the same cycle
      reset();
      sel(5, 1);
      sel(6, 3);
      Sel_Valid = 1'b1;
      Selected_Address = 6'd5;
      Selected_Data = 4'd4;
      Hour_Tick = 1'b1;
      step();
      Sel_Valid = 1'b0;
      Hour_Tick = 1'b0;
      step();
      check("t4_no_due", Alarm, 0);
      tick();
      step();
      check("t4_still_quiet", Alarm, 0);
      tick();
      step();
      check("t4_alarm6", Alarm, 1);
      check("t4_med6", Alarm_Med_Id, 6);
      // delete during alarm
      reset();
      sel(3, 1);
      tick();
      step();
      check("t5_alarm", Alarm, 1);
      check("t5_med", Alarm_Med_Id, 3);
      sel(3, 0);
      check("t5_dropped", Alarm, 0);
      check("t5_count", Active_Count, 0);
      ack();
      check("t5_ack_idle", Alarm, 0);
      step();
      check("t5_stays_idle", Alarm, 0);
      // asynchronous reset during alarm
      reset();
      sel(4, 1);
      tick();
      step();
      check("t6_alarm", Alarm, 1);
      #2 Rst = 1'b0;
      #1;
      check("t6_async_alarm", Alarm, 0);
      check("t6_async_med", Alarm_Med_Id, 0);
      check("t6_async_count", Active_Count, 0);
      step();
      Rst = 1'b1;
      step();
      check("t6_full", Full_Err, 0);
      tick();
      step();
      check("t6_no_alarm", Alarm, 0);
      check("t6_count", Active_Count, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
